// File: rtl/softusb_rx.sv
// USB receive front end: DPLL bit recovery, SYNC detect, NRZI decode,
// bit-unstuffing and LSB-first byte assembly with EOP / stuff-error signalling.
module softusb_rx (
    input  logic       usb_clk,
    input  logic       usb_rst,
    input  logic       low_speed,
    input  logic       tx_active,
    input  logic       rxd,
    input  logic       rxp,
    input  logic       rxm,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       rx_active,
    output logic       rx_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  phase_q, phase_d;
    logic        rxd_prev_q, rxd_prev_d;
    logic        prev_l_q, prev_l_d;
    logic [2:0]  zeros_q, zeros_d;
    logic [2:0]  ones_q, ones_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_strobe_q, rx_strobe_d;
    logic        rx_active_q, rx_active_d;
    logic        rx_error_q, rx_error_d;

    logic        se0;
    logic        line_l;
    logic        sample;
    logic        bit_dec;
    logic [4:0]  phase_mask;
    logic [4:0]  phase_half;

    assign se0        = !rxp && !rxm;
    assign line_l     = rxd ^ low_speed;
    assign phase_mask = low_speed ? 5'd31 : 5'd3;
    assign phase_half = low_speed ? 5'd16 : 5'd2;
    assign sample     = (phase_q == phase_half);
    assign bit_dec    = (line_l == prev_l_q);

    always_comb begin
        state_d     = state_q;
        rxd_prev_d  = rxd;
        prev_l_d    = (state_q == ST_IDLE) ? 1'b1 : prev_l_q;
        zeros_d     = zeros_q;
        ones_d      = ones_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_strobe_d = 1'b0;
        rx_active_d = rx_active_q;
        rx_error_d  = 1'b0;

        // Edges seen during SE0 carry no timing information, so they do not resync.
        if ((rxd != rxd_prev_q) && !se0) begin
            phase_d = 5'd0;
        end else begin
            phase_d = (phase_q + 5'd1) & phase_mask;
        end

        if (sample) begin
            case (state_q)
                ST_IDLE: begin
                    if (!se0 && !line_l) begin
                        state_d  = ST_SYNC;
                        zeros_d  = 3'd1;
                        prev_l_d = 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (se0) begin
                        state_d = ST_IDLE;
                    end else begin
                        prev_l_d = line_l;
                        if (!bit_dec) begin
                            zeros_d = (zeros_q == 3'd7) ? 3'd7 : zeros_q + 3'd1;
                        end else if (zeros_q >= 3'd3) begin
                            state_d     = ST_DATA;
                            rx_active_d = 1'b1;
                            ones_d      = 3'd1;
                            bitcnt_d    = 3'd0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (se0) begin
                        state_d = ST_EOP;
                    end else begin
                        prev_l_d = line_l;
                        if (ones_q == 3'd6) begin
                            if (!bit_dec) begin
                                ones_d = 3'd0;
                            end else begin
                                state_d     = ST_ERROR;
                                rx_error_d  = 1'b1;
                                rx_active_d = 1'b0;
                            end
                        end else begin
                            shift_d  = {bit_dec, shift_q[7:1]};
                            bitcnt_d = bitcnt_q + 3'd1;
                            ones_d   = bit_dec ? ones_q + 3'd1 : 3'd0;
                            if (bitcnt_q == 3'd7) begin
                                rx_data_d   = {bit_dec, shift_q[7:1]};
                                rx_strobe_d = 1'b1;
                            end
                        end
                    end
                end
                ST_EOP: begin
                    if (!se0 && line_l) begin
                        state_d     = ST_IDLE;
                        rx_active_d = 1'b0;
                    end
                end
                ST_ERROR: begin
                    // Reuse EOP's wait-for-J once SE0 has been seen; rx_active is already low.
                    if (se0) begin
                        state_d = ST_EOP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (tx_active) begin
            state_d     = ST_IDLE;
            prev_l_d    = 1'b1;
            rx_strobe_d = 1'b0;
            rx_active_d = 1'b0;
            rx_error_d  = 1'b0;
        end
    end

    always_ff @(posedge usb_clk) begin
        if (usb_rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 5'd0;
            rxd_prev_q  <= 1'b0;
            prev_l_q    <= 1'b1;
            zeros_q     <= 3'd0;
            ones_q      <= 3'd0;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_strobe_q <= 1'b0;
            rx_active_q <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            rxd_prev_q  <= rxd_prev_d;
            prev_l_q    <= prev_l_d;
            zeros_q     <= zeros_d;
            ones_q      <= ones_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_strobe_q <= rx_strobe_d;
            rx_active_q <= rx_active_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_strobe = rx_strobe_q;
    assign rx_active = rx_active_q;
    assign rx_error  = rx_error_q;

endmodule

// File: tb/tb_softusb_rx.sv
// Bench for softusb_rx: encodes packets (SYNC, NRZI, bit stuffing, EOP) onto the
// line and compares received bytes, timing and status against the encoder's record.
module tb_softusb_rx;

    logic       usb_clk = 1'b0;
    logic       usb_rst;
    logic       low_speed;
    logic       tx_active;
    logic       rxd;
    logic       rxp;
    logic       rxm;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       rx_active;
    logic       rx_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int strb_data[$];
    int strb_cyc[$];
    int err_cnt = 0;
    int act_cnt = 0;
    int ovl_cnt = 0;

    int pay_q[$];
    int wire_q[$];   // 0 = K, 1 = J, 2 = SE0
    int exp_q[$];
    int exp_k[$];    // wire index of the last data bit of each expected byte
    int kj;          // wire index of the first J after EOP

    softusb_rx dut (
        .usb_clk   (usb_clk),
        .usb_rst   (usb_rst),
        .low_speed (low_speed),
        .tx_active (tx_active),
        .rxd       (rxd),
        .rxp       (rxp),
        .rxm       (rxm),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .rx_active (rx_active),
        .rx_error  (rx_error)
    );

    always #5 usb_clk = ~usb_clk;

    always @(posedge usb_clk) cyc <= cyc + 1;

    always @(negedge usb_clk) begin
        if (rx_strobe) begin
            strb_data.push_back(int'(rx_data));
            strb_cyc.push_back(cyc);
        end
        if (rx_error) err_cnt <= err_cnt + 1;
        if (rx_active) act_cnt <= act_cnt + 1;
        if (rx_strobe && rx_error) ovl_cnt <= ovl_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_line(input int lvl, input int ls);
        if (lvl == 2) begin
            rxp = 1'b0;
            rxm = 1'b0;
            rxd = (ls == 0) ? 1'b1 : 1'b0;
        end else begin
            rxd = ((lvl ^ ls) & 1) != 0;
            rxp = rxd;
            rxm = ~rxd;
        end
    endtask

    task automatic hold(input int lvl, input int ls, input int n);
        set_line(lvl, ls);
        repeat (n) @(posedge usb_clk);
        #1;
    endtask

    // Encoder: SYNC, LSB-first data with a 0 stuffed after six 1s (SYNC's last bit counts), EOP.
    task automatic build(input int short_sync, input int nbits_limit, input int violate);
        int lvl;
        int ones;
        int nd;
        int bit_v;
        bit stop;
        wire_q.delete();
        exp_q.delete();
        exp_k.delete();
        lvl = 1;
        kj = -1;
        if (short_sync != 0) begin
            wire_q.push_back(0);
            wire_q.push_back(1);
            wire_q.push_back(1);
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (i < 7) lvl = 1 - lvl;
                wire_q.push_back(lvl);
            end
            ones = 1;
            nd = 0;
            stop = 1'b0;
            foreach (pay_q[j]) begin
                for (int i = 0; i < 8 && !stop; i++) begin
                    if (nd == nbits_limit) begin
                        stop = 1'b1;
                    end else begin
                        bit_v = (pay_q[j] >> i) & 1;
                        if (bit_v == 0) lvl = 1 - lvl;
                        wire_q.push_back(lvl);
                        nd++;
                        ones = (bit_v != 0) ? ones + 1 : 0;
                        if (i == 7) begin
                            exp_q.push_back(pay_q[j]);
                            exp_k.push_back(wire_q.size() - 1);
                        end
                        if (ones == 6) begin
                            if (violate != 0) begin
                                wire_q.push_back(lvl);
                                stop = 1'b1;
                            end else begin
                                lvl = 1 - lvl;
                                wire_q.push_back(lvl);
                                ones = 0;
                            end
                        end
                    end
                end
            end
            wire_q.push_back(2);
            wire_q.push_back(2);
            kj = wire_q.size();
        end
        repeat (4) wire_q.push_back(1);
    endtask

    task automatic send(input int ls, input int per, output int e0);
        e0 = cyc;
        foreach (wire_q[k]) hold(wire_q[k], ls, per);
    endtask

    task automatic run_pkt(input string name, input int ls, input int drift,
                           input int short_sync, input int nbits_limit, input int violate);
        int p;
        int e0;
        int b_s;
        int b_err;
        int b_act;
        int b_ovl;
        p = (ls != 0) ? 32 : 4;
        low_speed = (ls != 0);
        hold(1, ls, 3 * p);
        build(short_sync, nbits_limit, violate);
        b_s = strb_data.size();
        b_err = err_cnt;
        b_act = act_cnt;
        b_ovl = ovl_cnt;
        send(ls, p + drift, e0);
        check($sformatf("%s_nstrobe", name), strb_data.size() - b_s, exp_q.size());
        for (int i = 0; i < exp_q.size() && b_s + i < strb_data.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), strb_data[b_s + i], exp_q[i]);
            if (drift == 0)
                check($sformatf("%s_time%0d", name, i), strb_cyc[b_s + i], e0 + p * exp_k[i] + p / 2 + 2);
        end
        check($sformatf("%s_errors", name), err_cnt - b_err, violate);
        check($sformatf("%s_overlap", name), ovl_cnt - b_ovl, 0);
        if (violate == 0 && drift == 0)
            check($sformatf("%s_active_cycles", name), act_cnt - b_act,
                  (short_sync != 0) ? 0 : (kj - 7) * p);
        check($sformatf("%s_active_end", name), int'(rx_active), 0);
        $display("packet %s ls=%0d drift=%0d bytes=%0d strobes=%0d", name, ls, drift,
                 exp_q.size(), strb_data.size() - b_s);
    endtask

    // Interrupts a packet of 0xFF bytes mid-first-byte by tx_active (kind 0) or usb_rst (kind 1).
    task automatic run_intr(input string name, input int kind);
        int e0;
        int b_s;
        int b_err;
        low_speed = 1'b0;
        hold(1, 0, 12);
        pay_q = '{8'hFF, 8'hFF, 8'hFF};
        build(0, -1, 0);
        b_s = strb_data.size();
        b_err = err_cnt;
        fork
            send(0, 4, e0);
            begin
                repeat (46) @(posedge usb_clk);
                #1;
                check($sformatf("%s_pre_active", name), int'(rx_active), 1);
                if (kind == 0) tx_active = 1'b1;
                else usb_rst = 1'b1;
                @(posedge usb_clk);
                @(negedge usb_clk);
                check($sformatf("%s_post_active", name), int'(rx_active), 0);
                check($sformatf("%s_post_strobe", name), int'(rx_strobe), 0);
                check($sformatf("%s_post_error", name), int'(rx_error), 0);
                if (kind != 0) check($sformatf("%s_post_data", name), int'(rx_data), 0);
                usb_rst = 1'b0;
            end
        join
        tx_active = 1'b0;
        hold(1, 0, 12);
        check($sformatf("%s_nstrobe", name), strb_data.size() - b_s, 0);
        check($sformatf("%s_errors", name), err_cnt - b_err, 0);
        check($sformatf("%s_active_end", name), int'(rx_active), 0);
        $display("interrupt %s kind=%0d strobes=%0d", name, kind, strb_data.size() - b_s);
    endtask

    initial begin
        int ls;
        int drift;
        int nb;
        usb_rst = 1'b1;
        tx_active = 1'b0;
        low_speed = 1'b0;
        set_line(1, 0);
        repeat (3) @(posedge usb_clk);
        @(negedge usb_clk);
        check("reset_data", int'(rx_data), 0);
        check("reset_strobe", int'(rx_strobe), 0);
        check("reset_active", int'(rx_active), 0);
        check("reset_error", int'(rx_error), 0);
        @(posedge usb_clk);
        #1;
        usb_rst = 1'b0;

        pay_q = '{8'hA5};
        run_pkt("fs_a5", 0, 0, 0, -1, 0);
        pay_q = '{8'hFF, 8'h01};
        run_pkt("fs_stuff", 0, 0, 0, -1, 0);
        pay_q = '{8'hFF, 8'h00};
        run_pkt("fs_violate", 0, 0, 0, -1, 1);
        pay_q = '{8'h3C};
        run_pkt("fs_after_err", 0, 0, 0, -1, 0);
        pay_q = '{8'hC3};
        run_pkt("ls_c3", 1, 0, 0, -1, 0);
        pay_q = '{8'hC3, 8'h5A};
        run_pkt("ls_slow", 1, 1, 0, -1, 0);
        run_pkt("ls_fast", 1, -1, 0, -1, 0);
        run_pkt("short_sync", 0, 0, 1, -1, 0);
        pay_q = '{8'hA5};
        run_pkt("dribble", 0, 0, 0, 3, 0);
        run_intr("txa", 0);
        pay_q = '{8'h5A};
        run_pkt("after_txa", 0, 0, 0, -1, 0);
        run_intr("rst", 1);
        run_pkt("after_rst", 0, 0, 0, -1, 0);

        for (int n = 0; n < 10; n++) begin
            ls = $urandom_range(0, 1);
            drift = (ls != 0) ? int'($urandom_range(0, 2)) - 1 : 0;
            nb = $urandom_range(1, 3);
            pay_q.delete();
            for (int b = 0; b < nb; b++)
                pay_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : int'($urandom_range(0, 255)));
            run_pkt($sformatf("rnd%0d", n), ls, drift, 0, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
